// File: rtl/sram_2p_pipe_pkg.sv
// Shared types and helpers for the two-port SRAM slice: state encoding,
// default lane geometry and the byte-lane merge used by write and forwarding.
package sram_pkg;

    typedef enum logic {CLEAR, RUN} state_e;

    localparam int DW_DEF = 32;
    localparam int BW_DEF = 8;
    localparam int NBE    = DW_DEF / BW_DEF;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_DW = 256;

    function automatic logic [MAX_DW-1:0] be_merge(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_DW-1:0] be,
        input int                bw
    );
        logic [MAX_DW-1:0] res;
        for (int b = 0; b < MAX_DW; b++) begin
            res[b] = be[b / bw] ? new_w[b] : old_w[b];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_2p_pipe_if.sv
// Port bundle for sram_2p_pipe: write port A, read port B and the ready flag.
interface sram_2p_pipe_if #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int BW = 8
);
    localparam int NB = DW / BW;

    logic          iWrA;
    logic [NB-1:0] iBeA;
    logic [AW-1:0] iAddrA;
    logic [DW-1:0] iDataA;
    logic          iRdB;
    logic [AW-1:0] iAddrB;
    logic [DW-1:0] oDataB;
    logic          oValidB;
    logic          oReady;

    modport slave (
        input  iWrA, iBeA, iAddrA, iDataA, iRdB, iAddrB,
        output oDataB, oValidB, oReady
    );

    modport master (
        output iWrA, iBeA, iAddrA, iDataA, iRdB, iAddrB,
        input  oDataB, oValidB, oReady
    );
endinterface

// File: rtl/sram_2p_pipe_clr_ctrl.sv
// Clear-sweep controller: owns the CLEAR/RUN state, the sweep counter and the
// ready flag, and muxes the array write port between the sweep and port A.
module sram_clr_ctrl
    import sram_pkg::*;
#(
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int NB           = 4,
    parameter int DEPTH        = 1 << AW,
    parameter int CLR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_i,
    input  logic [NB-1:0] be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    output logic          mem_we_o,
    output logic [NB-1:0] mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          ready_o
);
    localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
    localparam state_e        RST_STATE = (CLR_ON_RESET != 0) ? CLEAR : RUN;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          in_range;

    assign in_range = {1'b0, addr_i} < DEPTH_W;
    assign ready_o  = ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Array writes are suppressed while reset is held so reset leaves contents alone.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        mem_we_o    = 1'b0;
        mem_be_o    = be_i;
        mem_addr_o  = addr_i;
        mem_wdata_o = data_i;
        case (state_q)
            CLEAR: begin
                mem_we_o    = ~reset;
                mem_be_o    = '1;
                mem_addr_o  = cnt_q;
                mem_wdata_o = '0;
                cnt_d       = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                ready_d  = 1'b1;
                mem_we_o = wr_i & ready_q & in_range & ~reset;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/sram_2p_pipe.sv
// Two-port SRAM with byte-lane writes, write-first forwarding, 1- or 2-cycle
// read latency with a valid strobe, and an optional clear sweep after reset.
module sram_2p_pipe
    import sram_pkg::*;
#(
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int DEPTH        = 1 << AW,
    parameter int BW           = 8,
    parameter int RD_LAT       = 1,
    parameter int CLR_ON_RESET = 1
) (
    input  logic           clk,
    input  logic           reset,
    sram_2p_pipe_if.slave  bus
);
    localparam int          NB      = DW / BW;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    if (DW % BW != 0) begin : g_bad_bw
        $error("sram_2p_pipe: DW must be a multiple of BW");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("sram_2p_pipe: RD_LAT must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > (1 << AW)) begin : g_bad_depth
        $error("sram_2p_pipe: DEPTH must be in 1..2**AW");
    end
    if (DW > MAX_DW) begin : g_bad_dw
        $error("sram_2p_pipe: DW exceeds MAX_DW");
    end

    logic          mem_we;
    logic [NB-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          ready;

    sram_clr_ctrl #(
        .AW           (AW),
        .DW           (DW),
        .NB           (NB),
        .DEPTH        (DEPTH),
        .CLR_ON_RESET (CLR_ON_RESET)
    ) u_clr (
        .clk         (clk),
        .reset       (reset),
        .wr_i        (bus.iWrA),
        .be_i        (bus.iBeA),
        .addr_i      (bus.iAddrA),
        .data_i      (bus.iDataA),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .ready_o     (ready)
    );

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= DW'(be_merge(MAX_DW'(mem[mem_addr]), MAX_DW'(mem_wdata),
                                          MAX_DW'(mem_be), BW));
        end
    end

    logic          rd_fire;
    logic          rd_in_range;
    logic          fwd;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] rd_data;

    // Write-first: a same-address write in the sampling cycle overrides its enabled lanes.
    always_comb begin
        rd_fire     = bus.iRdB & ready;
        rd_in_range = {1'b0, bus.iAddrB} < DEPTH_W;
        fwd         = bus.iWrA & ready & (bus.iAddrA == bus.iAddrB);
        rd_word     = mem[bus.iAddrB];
        rd_data     = '0;
        if (rd_in_range) begin
            rd_data = fwd ? DW'(be_merge(MAX_DW'(rd_word), MAX_DW'(bus.iDataA),
                                         MAX_DW'(bus.iBeA), BW))
                          : rd_word;
        end
    end

    logic [RD_LAT:1] vld_pipe_q;
    logic [DW-1:0]   dat_pipe_q [1:RD_LAT];

    // Data stages only load on a valid, so oDataB holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q <= '0;
            for (int k = 1; k <= RD_LAT; k++) dat_pipe_q[k] <= '0;
        end else begin
            vld_pipe_q[1] <= rd_fire;
            if (rd_fire) dat_pipe_q[1] <= rd_data;
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                if (vld_pipe_q[k-1]) dat_pipe_q[k] <= dat_pipe_q[k-1];
            end
        end
    end

    assign bus.oDataB  = dat_pipe_q[RD_LAT];
    assign bus.oValidB = vld_pipe_q[RD_LAT];
    assign bus.oReady  = ready;
endmodule

// File: tb/tb_sram_2p_pipe.sv
// Bench: three DUT flavours (DEPTH8/LAT1, DEPTH6/LAT1, DEPTH8/LAT2) share one
// stimulus stream; a word-level memory model predicts every output each cycle.
module tb_sram_2p_pipe;
    logic        clk;
    logic        reset;
    logic        wr, rd;
    logic [3:0]  be;
    logic [2:0]  addrA, addrB;
    logic [31:0] dataA;

    sram_2p_pipe_if #(.AW(3), .DW(32), .BW(8)) if0 ();
    sram_2p_pipe_if #(.AW(3), .DW(32), .BW(8)) if1 ();
    sram_2p_pipe_if #(.AW(3), .DW(32), .BW(8)) if2 ();

    assign if0.iWrA = wr; assign if0.iBeA = be; assign if0.iAddrA = addrA;
    assign if0.iDataA = dataA; assign if0.iRdB = rd; assign if0.iAddrB = addrB;
    assign if1.iWrA = wr; assign if1.iBeA = be; assign if1.iAddrA = addrA;
    assign if1.iDataA = dataA; assign if1.iRdB = rd; assign if1.iAddrB = addrB;
    assign if2.iWrA = wr; assign if2.iBeA = be; assign if2.iAddrA = addrA;
    assign if2.iDataA = dataA; assign if2.iRdB = rd; assign if2.iAddrB = addrB;

    sram_2p_pipe #(.AW(3), .DW(32), .DEPTH(8), .BW(8), .RD_LAT(1), .CLR_ON_RESET(1))
        u0 (.clk(clk), .reset(reset), .bus(if0));
    sram_2p_pipe #(.AW(3), .DW(32), .DEPTH(6), .BW(8), .RD_LAT(1), .CLR_ON_RESET(1))
        u1 (.clk(clk), .reset(reset), .bus(if1));
    sram_2p_pipe #(.AW(3), .DW(32), .DEPTH(8), .BW(8), .RD_LAT(2), .CLR_ON_RESET(1))
        u2 (.clk(clk), .reset(reset), .bus(if2));

    logic        act_rdy [3];
    logic        act_vld [3];
    logic [31:0] act_dat [3];
    assign act_rdy[0] = if0.oReady; assign act_vld[0] = if0.oValidB; assign act_dat[0] = if0.oDataB;
    assign act_rdy[1] = if1.oReady; assign act_vld[1] = if1.oValidB; assign act_dat[1] = if1.oDataB;
    assign act_rdy[2] = if2.oReady; assign act_vld[2] = if2.oValidB; assign act_dat[2] = if2.oDataB;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: word memory plus "edges since reset released".
    int          depth_m [3] = '{8, 6, 8};
    int          lat_m   [3] = '{1, 1, 2};
    logic [31:0] mem_m   [3][8];
    int          since   [3];
    logic        e_rdy   [3];
    logic        e_vld   [3];
    logic [31:0] e_dat   [3];
    logic        s_vld   [3];
    logic [31:0] s_dat   [3];

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                since[d] = 0; e_rdy[d] = 1'b0; e_vld[d] = 1'b0;
                e_dat[d] = '0; s_vld[d] = 1'b0;
            end else begin
                logic        acc;
                logic        rv;
                logic [31:0] val;
                acc = e_rdy[d];
                // Applying the write before the read gives write-first semantics.
                if (acc && wr && int'(addrA) < depth_m[d])
                    for (int l = 0; l < 4; l++)
                        if (be[l]) mem_m[d][addrA][l*8 +: 8] = dataA[l*8 +: 8];
                rv  = acc && rd;
                val = (int'(addrB) < depth_m[d]) ? mem_m[d][addrB] : 32'h0;
                if (lat_m[d] == 1) begin
                    e_vld[d] = rv;
                    if (rv) e_dat[d] = val;
                end else begin
                    e_vld[d] = s_vld[d];
                    if (s_vld[d]) e_dat[d] = s_dat[d];
                    s_vld[d] = rv;
                    s_dat[d] = val;
                end
                since[d]++;
                if (since[d] >= depth_m[d]) e_rdy[d] = 1'b1;
                if (since[d] == depth_m[d])
                    for (int a = 0; a < 8; a++) mem_m[d][a] = '0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 3; d++) begin
                    check($sformatf("ready%0d", d), 32'(act_rdy[d]), 32'(e_rdy[d]));
                    check($sformatf("valid%0d", d), 32'(act_vld[d]), 32'(e_vld[d]));
                    check($sformatf("data%0d", d), act_dat[d], e_dat[d]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic w, input logic [3:0] b, input int aA,
                          input logic [31:0] dA, input logic r, input int aB);
        wr = w; be = b; addrA = 3'(aA); dataA = dA; rd = r; addrB = 3'(aB);
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 4'h0, 0, 32'h0, 0, 0);
        for (int d = 0; d < 3; d++) begin
            since[d] = 0; e_rdy[d] = 0; e_vld[d] = 0; e_dat[d] = 0; s_vld[d] = 0; s_dat[d] = 0;
            for (int a = 0; a < 8; a++) mem_m[d][a] = '0;
        end
        tick();
        chk_en = 1'b1;
        tick();
        check("lit_rst_ready", 32'(act_rdy[0]), 32'h0);
        check("lit_rst_data", act_dat[0], 32'h0);
        reset = 1'b0;

        // Clear sweep, with a write attempt that must be ignored by u0.
        set_in(1, 4'hF, 2, 32'hFFFF_FFFF, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("lit_clr_ready0", 32'(act_rdy[0]), 32'(k == 8));
            check("lit_clr_ready1", 32'(act_rdy[1]), 32'(k >= 6));
        end
        for (int k = 0; k < 8; k++) begin
            set_in(0, 4'h0, 0, 32'h0, 1, k);
            tick();
            check("lit_clr_rd_vld", 32'(act_vld[0]), 32'h1);
            check("lit_clr_rd_dat", act_dat[0], 32'h0);
        end

        // Byte-lane write and latency.
        set_in(1, 4'hF, 3, 32'hDEAD_BEEF, 0, 0); tick();
        set_in(1, 4'h5, 3, 32'h1122_3344, 0, 0); tick();
        set_in(0, 4'h0, 0, 32'h0, 1, 3); tick();
        check("lit_be_dat0", act_dat[0], 32'hDE22_BE44);
        check("lit_be_vld2", 32'(act_vld[2]), 32'h0);
        set_in(0, 4'h0, 0, 32'h0, 0, 0); tick();
        check("lit_be_dat2", act_dat[2], 32'hDE22_BE44);
        check("lit_be_vld0", 32'(act_vld[0]), 32'h0);

        // Collision: write-first with partial lanes.
        set_in(1, 4'hF, 5, 32'h1234_5678, 0, 0); tick();
        set_in(1, 4'h3, 5, 32'hCAFE_F00D, 1, 5); tick();
        check("lit_fwd_dat", act_dat[0], 32'h1234_F00D);
        set_in(0, 4'h0, 0, 32'h0, 1, 5); tick();
        check("lit_fwd_again", act_dat[0], 32'h1234_F00D);
        set_in(0, 4'h0, 0, 32'h0, 0, 0); tick();

        // Back-to-back reads.
        for (int k = 0; k < 8; k++) begin
            set_in(1, 4'hF, k, 32'(k) * 32'h0101_0101, 0, 0); tick();
        end
        for (int k = 0; k < 8; k++) begin
            set_in(0, 4'h0, 0, 32'h0, 1, k); tick();
            check("lit_b2b_vld", 32'(act_vld[0]), 32'h1);
            check("lit_b2b_dat", act_dat[0], 32'(k) * 32'h0101_0101);
        end
        set_in(0, 4'h0, 0, 32'h0, 0, 0); tick();
        check("lit_hold_vld", 32'(act_vld[0]), 32'h0);
        check("lit_hold_dat", act_dat[0], 32'h0707_0707);
        check("lit_lat2_last", act_dat[2], 32'h0707_0707);
        tick();

        // Out-of-range on the DEPTH=6 instance.
        set_in(1, 4'hF, 7, 32'hAAAA_AAAA, 0, 0); tick();
        set_in(0, 4'h0, 0, 32'h0, 1, 7); tick();
        check("lit_oor_vld", 32'(act_vld[1]), 32'h1);
        check("lit_oor_dat", act_dat[1], 32'h0);
        set_in(0, 4'h0, 0, 32'h0, 1, 5); tick();
        check("lit_oor_keep", act_dat[1], 32'h0505_0505);

        // Reset with a RD_LAT=2 read in flight.
        set_in(0, 4'h0, 0, 32'h0, 1, 3); tick();
        reset = 1'b1;
        set_in(0, 4'h0, 0, 32'h0, 0, 0); tick();
        check("lit_rst_lat2_vld", 32'(act_vld[2]), 32'h0);
        check("lit_rst_lat2_dat", act_dat[2], 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("lit_reclr_ready2", 32'(act_rdy[2]), 32'(k == 8));
        end
        set_in(0, 4'h0, 0, 32'h0, 1, 3); tick();
        check("lit_reclr_dat", act_dat[0], 32'h0);
        set_in(0, 4'h0, 0, 32'h0, 0, 0); tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
